// File: rtl/phy_scan_pkg.sv
// Shared types and constants for the phy_channel scan sequencer.
package phy_scan_pkg;

  localparam int unsigned NUM_VCHN = 4;
  localparam int unsigned SLOT_W   = 16;
  localparam int unsigned VCHN_W   = 2;
  localparam int unsigned IDX_W    = VCHN_W + 1;
  localparam int unsigned CFG_W    = 8;
  localparam int unsigned CNT_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SLOT,
    ST_COMPLETE,
    ST_WAIT
  } state_t;

  typedef struct packed {
    logic              en;
    logic [CFG_W-1:0]  len;
    logic [CFG_W-1:0]  delay;
    logic [CFG_W-1:0]  ratio;
    logic [SLOT_W-1:0] slot_len;
  } vchn_cfg_t;

  localparam vchn_cfg_t CFG_RST = '{
    en:       1'b0,
    len:      '0,
    delay:    '0,
    ratio:    CFG_W'(1),
    slot_len: SLOT_W'(1)
  };

  // Lowest enabled vchn at or above 'from'; MSB of the result flags a hit.
  function automatic logic [IDX_W-1:0] find_next_en(input logic [NUM_VCHN-1:0] en,
                                                     input logic [IDX_W-1:0]    from);
    logic [IDX_W-1:0] res;
    res = '0;
    for (int i = 0; i < NUM_VCHN; i++) begin
      if (!res[VCHN_W] && en[i] && (IDX_W'(i) >= from)) res = {1'b1, VCHN_W'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/phy_scan_cfg_regs.sv
// Live configuration bank (host writes) and shadow bank frozen at cycle start.
module phy_scan_cfg_regs
  import phy_scan_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr,
  input  logic [VCHN_W-1:0]   wr_vchn,
  input  vchn_cfg_t           wr_cfg,
  input  logic                capture,
  input  logic [VCHN_W-1:0]   rd_vchn,
  output logic [CFG_W-1:0]    rd_len_c,
  output logic [CFG_W-1:0]    rd_delay_c,
  output logic [CFG_W-1:0]    rd_ratio_c,
  output logic [SLOT_W-1:0]   rd_slot_len_c,
  output logic [NUM_VCHN-1:0] live_en_c,
  output logic [NUM_VCHN-1:0] shadow_en_c
);

  vchn_cfg_t live   [NUM_VCHN];
  vchn_cfg_t shadow [NUM_VCHN];

  // Capture copies the pre-write live bank, so a same-cycle write lands only in live.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VCHN; i++) begin
        live[i]   <= CFG_RST;
        shadow[i] <= CFG_RST;
      end
    end else begin
      if (wr) live[wr_vchn] <= wr_cfg;
      if (capture) shadow <= live;
    end
  end

  // While capturing, the shadow is not yet loaded; read the live values it is about to take.
  assign rd_len_c      = capture ? live[rd_vchn].len      : shadow[rd_vchn].len;
  assign rd_delay_c    = capture ? live[rd_vchn].delay    : shadow[rd_vchn].delay;
  assign rd_ratio_c    = capture ? live[rd_vchn].ratio    : shadow[rd_vchn].ratio;
  assign rd_slot_len_c = capture ? live[rd_vchn].slot_len : shadow[rd_vchn].slot_len;

  always_comb begin
    for (int i = 0; i < NUM_VCHN; i++) begin
      live_en_c[i]   = live[i].en;
      shadow_en_c[i] = shadow[i].en;
    end
  end

endmodule

// File: rtl/phy_scan_ctrl.sv
// Scan sequencer: cycle sync, per-slot sync/config for phy_channel, period pacing.
module phy_scan_ctrl
  import phy_scan_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_run,
  input  logic [SLOT_W-1:0] i_period,
  input  logic              i_cfg_wr,
  input  logic [VCHN_W-1:0] i_cfg_vchn,
  input  logic              i_cfg_en,
  input  logic [CFG_W-1:0]  i_cfg_len,
  input  logic [CFG_W-1:0]  i_cfg_delay,
  input  logic [CFG_W-1:0]  i_cfg_ratio,
  input  logic [SLOT_W-1:0] i_cfg_slot_len,
  output logic              o_sync,
  output logic              o_slot_sync,
  output logic [VCHN_W-1:0] o_wr_vchn,
  output logic [CFG_W-1:0]  o_data_len,
  output logic [CFG_W-1:0]  o_adc_delay,
  output logic [CFG_W-1:0]  o_ratio,
  output logic              o_complite,
  output logic              o_busy,
  output logic              o_overrun,
  output logic [CNT_W-1:0]  o_cycle_cnt
);

  localparam int unsigned PCW = SLOT_W + 1;

  state_t              state, state_d;
  logic [SLOT_W-1:0]   scnt, pcnt;
  logic [PCW-1:0]      pcnt_inc;
  logic [IDX_W-1:0]    nxt;
  logic                load_slot, overrun_d, capture;
  logic [VCHN_W-1:0]   rd_vchn;
  logic [NUM_VCHN-1:0] live_en, shadow_en;
  logic [CFG_W-1:0]    rd_len, rd_delay, rd_ratio;
  logic [SLOT_W-1:0]   rd_slot_len;
  vchn_cfg_t           wr_cfg;

  assign wr_cfg = '{en: i_cfg_en, len: i_cfg_len, delay: i_cfg_delay,
                    ratio: i_cfg_ratio, slot_len: i_cfg_slot_len};
  assign capture  = (state == ST_SYNC);
  assign rd_vchn  = nxt[VCHN_W-1:0];
  assign pcnt_inc = PCW'(pcnt) + PCW'(1);

  phy_scan_cfg_regs u_cfg_regs (
    .clk           (clk),
    .rst           (rst),
    .wr            (i_cfg_wr),
    .wr_vchn       (i_cfg_vchn),
    .wr_cfg        (wr_cfg),
    .capture       (capture),
    .rd_vchn       (rd_vchn),
    .rd_len_c      (rd_len),
    .rd_delay_c    (rd_delay),
    .rd_ratio_c    (rd_ratio),
    .rd_slot_len_c (rd_slot_len),
    .live_en_c     (live_en),
    .shadow_en_c   (shadow_en)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    load_slot = 1'b0;
    overrun_d = 1'b0;
    nxt       = '0;
    case (state)
      ST_IDLE: if (i_run) state_d = ST_SYNC;
      ST_SYNC: begin
        nxt = find_next_en(live_en, '0);
        if (nxt[VCHN_W]) begin
          state_d   = ST_SLOT;
          load_slot = 1'b1;
        end else begin
          state_d = ST_COMPLETE;
        end
      end
      ST_SLOT: begin
        if (scnt == '0) begin
          nxt = find_next_en(shadow_en, IDX_W'(o_wr_vchn) + IDX_W'(1));
          if (nxt[VCHN_W]) load_slot = 1'b1;
          else             state_d   = ST_COMPLETE;
        end
      end
      ST_COMPLETE: state_d = i_run ? ST_WAIT : ST_IDLE;
      // Counter already past period-1 on entry means the cycle overran its period.
      ST_WAIT: begin
        if (pcnt_inc >= PCW'(i_period)) begin
          state_d   = ST_SYNC;
          overrun_d = (i_period != '0) && (pcnt_inc > PCW'(i_period));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scnt        <= '0;
      pcnt        <= '0;
      o_sync      <= 1'b0;
      o_slot_sync <= 1'b0;
      o_wr_vchn   <= '0;
      o_data_len  <= '0;
      o_adc_delay <= '0;
      o_ratio     <= '0;
      o_complite  <= 1'b0;
      o_busy      <= 1'b0;
      o_overrun   <= 1'b0;
      o_cycle_cnt <= '0;
    end else begin
      o_sync      <= (state_d == ST_SYNC);
      o_slot_sync <= load_slot;
      o_complite  <= (state_d == ST_COMPLETE);
      o_busy      <= (state_d == ST_SYNC) || (state_d == ST_SLOT) || (state_d == ST_COMPLETE);
      o_overrun   <= overrun_d;
      // pcnt counts clocks since the sync cycle, saturating.
      if (state == ST_SYNC)   pcnt <= SLOT_W'(1);
      else if (pcnt != '1)    pcnt <= pcnt + SLOT_W'(1);
      if (load_slot) begin
        scnt        <= (rd_slot_len == '0) ? '0 : rd_slot_len - SLOT_W'(1);
        o_wr_vchn   <= rd_vchn;
        o_data_len  <= rd_len;
        o_adc_delay <= rd_delay;
        o_ratio     <= rd_ratio;
      end else if (scnt != '0) begin
        scnt <= scnt - SLOT_W'(1);
      end
      if (state_d == ST_COMPLETE) o_cycle_cnt <= o_cycle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_phy_scan_ctrl.sv
// Bench for phy_scan_ctrl: expected event schedule derived per cycle from the configuration snapshot.
module tb_phy_scan_ctrl;
  import phy_scan_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_run;
  logic [SLOT_W-1:0] i_period;
  logic              i_cfg_wr;
  logic [VCHN_W-1:0] i_cfg_vchn;
  logic              i_cfg_en;
  logic [CFG_W-1:0]  i_cfg_len, i_cfg_delay, i_cfg_ratio;
  logic [SLOT_W-1:0] i_cfg_slot_len;
  logic              o_sync, o_slot_sync, o_complite, o_busy, o_overrun;
  logic [VCHN_W-1:0] o_wr_vchn;
  logic [CFG_W-1:0]  o_data_len, o_adc_delay, o_ratio;
  logic [CNT_W-1:0]  o_cycle_cnt;

  phy_scan_ctrl dut (
    .clk(clk), .rst(rst), .i_run(i_run), .i_period(i_period),
    .i_cfg_wr(i_cfg_wr), .i_cfg_vchn(i_cfg_vchn), .i_cfg_en(i_cfg_en),
    .i_cfg_len(i_cfg_len), .i_cfg_delay(i_cfg_delay), .i_cfg_ratio(i_cfg_ratio),
    .i_cfg_slot_len(i_cfg_slot_len),
    .o_sync(o_sync), .o_slot_sync(o_slot_sync), .o_wr_vchn(o_wr_vchn),
    .o_data_len(o_data_len), .o_adc_delay(o_adc_delay), .o_ratio(o_ratio),
    .o_complite(o_complite), .o_busy(o_busy), .o_overrun(o_overrun),
    .o_cycle_cnt(o_cycle_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct { int off; int v; int en; int len; int dl; int ra; int sl; } wr_t;
  wr_t wr_q[$];

  int m_en[NUM_VCHN], m_len[NUM_VCHN], m_dl[NUM_VCHN], m_ra[NUM_VCHN], m_sl[NUM_VCHN];
  int m_cnt, e_vchn, e_len, e_dl, e_ra;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_VCHN; i++) begin
      m_en[i] = 0; m_len[i] = 0; m_dl[i] = 0; m_ra[i] = 1; m_sl[i] = 1;
    end
    m_cnt = 0; e_vchn = 0; e_len = 0; e_dl = 0; e_ra = 0;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_sync"},      32'(o_sync),      32'(0));
    chk({tag, "_slot_sync"}, 32'(o_slot_sync), 32'(0));
    chk({tag, "_vchn"},      32'(o_wr_vchn),   32'(0));
    chk({tag, "_len"},       32'(o_data_len),  32'(0));
    chk({tag, "_delay"},     32'(o_adc_delay), 32'(0));
    chk({tag, "_ratio"},     32'(o_ratio),     32'(0));
    chk({tag, "_complite"},  32'(o_complite),  32'(0));
    chk({tag, "_busy"},      32'(o_busy),      32'(0));
    chk({tag, "_overrun"},   32'(o_overrun),   32'(0));
    chk({tag, "_cnt"},       32'(o_cycle_cnt), 32'(0));
  endtask

  task automatic drive_wr(input wr_t w);
    i_cfg_wr = 1'b1; i_cfg_vchn = VCHN_W'(w.v); i_cfg_en = 1'(w.en);
    i_cfg_len = CFG_W'(w.len); i_cfg_delay = CFG_W'(w.dl); i_cfg_ratio = CFG_W'(w.ra);
    i_cfg_slot_len = SLOT_W'(w.sl);
    m_en[w.v] = w.en; m_len[w.v] = w.len; m_dl[w.v] = w.dl; m_ra[w.v] = w.ra; m_sl[w.v] = w.sl;
  endtask

  task automatic q_wr(input int off, input int v, input int en, input int len,
                      input int dl, input int ra, input int sl);
    wr_t w;
    w = '{off: off, v: v, en: en, len: len, dl: dl, ra: ra, sl: sl};
    wr_q.push_back(w);
  endtask

  task automatic idle_wr(input int v, input int en, input int len, input int dl,
                         input int ra, input int sl);
    wr_t w;
    w = '{off: 0, v: v, en: en, len: len, dl: dl, ra: ra, sl: sl};
    drive_wr(w);
    @(negedge clk);
    i_cfg_wr = 1'b0;
  endtask

  task automatic start_run();
    i_run = 1'b1;
    @(negedge clk);
    chk("start_sync",    32'(o_sync),    32'(1));
    chk("start_overrun", 32'(o_overrun), 32'(0));
  endtask

  // Called at the negedge of a sync cycle; ends at the next sync (or idle after a drop).
  task automatic scan_cycle(input int period, input int drop_off, input int rst_off);
    int st_off[NUM_VCHN], st_v[NUM_VCHN], s_len[NUM_VCHN], s_dl[NUM_VCHN], s_ra[NUM_VCHN];
    int n, off, sum, gap, last, si;
    bit is_start;
    n = 0; off = 1; si = 0;
    for (int v = 0; v < NUM_VCHN; v++) begin
      if (m_en[v] != 0) begin
        st_off[n] = off; st_v[n] = v; s_len[n] = m_len[v]; s_dl[n] = m_dl[v]; s_ra[n] = m_ra[v];
        n++;
        off += (m_sl[v] == 0) ? 1 : m_sl[v];
      end
    end
    sum  = off - 1;
    gap  = (period > sum + 3) ? period : sum + 3;
    last = (drop_off >= 0) ? sum + 4 : gap;
    i_period = SLOT_W'(period);
    for (int k = 0; k < last; k++) begin
      is_start = (si < n) && (k == st_off[si]);
      if (is_start) begin
        e_vchn = st_v[si]; e_len = s_len[si]; e_dl = s_dl[si]; e_ra = s_ra[si];
        si++;
      end
      if (k == sum + 1) m_cnt = (m_cnt + 1) & 32'hffff;
      chk("sync",      32'(o_sync),      32'(k == 0));
      chk("slot_sync", 32'(o_slot_sync), 32'(is_start));
      chk("complite",  32'(o_complite),  32'(k == sum + 1));
      chk("busy",      32'(o_busy),      32'(k <= sum + 1));
      if (k != 0) chk("overrun", 32'(o_overrun), 32'(0));
      chk("vchn",      32'(o_wr_vchn),   32'(e_vchn));
      chk("data_len",  32'(o_data_len),  32'(e_len));
      chk("adc_delay", 32'(o_adc_delay), 32'(e_dl));
      chk("ratio",     32'(o_ratio),     32'(e_ra));
      chk("cycle_cnt", 32'(o_cycle_cnt), 32'(m_cnt));
      i_cfg_wr = 1'b0;
      if (k == rst_off) begin
        rst = 1'b1; i_run = 1'b0;
        @(negedge clk);
        model_reset();
        check_zero("rst_mid");
        @(negedge clk);
        check_zero("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_zero("rst_idle");
        wr_q.delete();
        return;
      end
      if (k == drop_off) i_run = 1'b0;
      if (wr_q.size() > 0 && wr_q[0].off == k) drive_wr(wr_q.pop_front());
      @(negedge clk);
    end
    i_cfg_wr = 1'b0;
    wr_q.delete();
    if (drop_off >= 0) begin
      chk("idle_sync", 32'(o_sync), 32'(0));
      chk("idle_busy", 32'(o_busy), 32'(0));
    end else begin
      chk("next_sync",      32'(o_sync),     32'(1));
      chk("next_overrun",   32'(o_overrun),  32'((period != 0) && (period < sum + 3)));
      chk("next_complite",  32'(o_complite), 32'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int per, o1, o2;
    rst = 1'b1; i_run = 1'b0; i_period = '0; i_cfg_wr = 1'b0; i_cfg_vchn = '0; i_cfg_en = 1'b0;
    i_cfg_len = '0; i_cfg_delay = '0; i_cfg_ratio = '0; i_cfg_slot_len = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle");

    // Four slots of 10 at period 100.
    for (int v = 0; v < NUM_VCHN; v++)
      idle_wr(v, 1, int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
              int'($urandom_range(255, 0)), 10);
    start_run();
    scan_cycle(100, -1, -1);

    // Writes in the sync cycle and mid-slot apply only to the following cycle.
    q_wr(0, 2, 1, 8, 3, 2, 20);
    q_wr(5, 0, 0, 0, 0, 1, 1);
    q_wr(6, 1, 0, 0, 0, 1, 1);
    q_wr(7, 3, 0, 0, 0, 1, 1);
    scan_cycle(100, -1, -1);
    q_wr(3, 2, 0, 8, 3, 2, 20);
    scan_cycle(100, -1, -1);

    // Empty cycle at period 0, then long slots that overrun period 50.
    q_wr(1, 0, 1, 11, 12, 13, 30);
    q_wr(2, 1, 1, 21, 22, 23, 30);
    scan_cycle(0, -1, -1);
    q_wr(10, 2, 1, 31, 32, 33, 30);
    q_wr(11, 3, 1, 41, 42, 43, 30);
    scan_cycle(50, -1, -1);
    scan_cycle(50, -1, -1);
    scan_cycle(50, -1, -1);

    // Randomized configuration and period.
    for (int c = 0; c < 8; c++) begin
      o1 = int'($urandom_range(5, 0));
      o2 = o1 + 1 + int'($urandom_range(6, 0));
      q_wr(o1, int'($urandom_range(3, 0)), int'($urandom_range(1, 0)), int'($urandom_range(255, 0)),
           int'($urandom_range(255, 0)), int'($urandom_range(255, 0)), int'($urandom_range(8, 0)));
      q_wr(o2, int'($urandom_range(3, 0)), int'($urandom_range(1, 0)), int'($urandom_range(255, 0)),
           int'($urandom_range(255, 0)), int'($urandom_range(255, 0)), int'($urandom_range(8, 0)));
      per = int'($urandom_range(60, 0));
      scan_cycle(per, (c == 7) ? 0 : -1, -1);
    end

    // Run dropped mid-slot 1, then reset during slot 2 of a later cycle.
    for (int v = 0; v < NUM_VCHN; v++)
      idle_wr(v, 1, int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
              int'($urandom_range(255, 0)), 6);
    start_run();
    scan_cycle(40, 9, -1);
    start_run();
    scan_cycle(40, -1, 15);

    // Live bank is back to defaults: nothing enabled.
    start_run();
    scan_cycle(0, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
